// File: rtl/ahbl_arbiter_pkg.sv
// ahbl_arbiter_pkg: shared busfabric transfer encodings and per-port field widths
package ahbl_arbiter_pkg;
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam int W_TRANS = 2;
    localparam int W_SIZE  = 3;
    localparam int W_BURST = 3;
    localparam int W_PROT  = 4;
endpackage

// File: rtl/ahbl_arb_pick.sv
// ahbl_arb_pick: one-hot grant from a request vector, round-robin under AHBL_ARBITER_ROUND_ROBIN_EN, fixed lowest-index priority otherwise
module ahbl_arb_pick #(
    parameter int N = 2
) (
`ifdef AHBL_ARBITER_ROUND_ROBIN_EN
    input  logic         clk,
    input  logic         rst_n,
    input  logic         adv,
`endif
    input  logic [N-1:0] req,
    output logic [N-1:0] grant
);
`ifdef AHBL_ARBITER_ROUND_ROBIN_EN
    logic [N-1:0] last;
    logic [N-1:0] hi;
    // requests above the last winner go first, otherwise wrap to the lowest requester
    always_comb begin
        hi = req & ~((last << 1) - N'(1));
        grant = (hi != '0) ? hi & (~hi + N'(1)) : req & (~req + N'(1));
    end
    // one-hot last-grant pointer, resets to the top port so port 0 is searched first
    always_ff @(posedge clk)
        if (!rst_n) last <= N'(1) << (N - 1);
        else if (adv) last <= grant;
`else
    // lowest set request bit wins
    always_comb grant = req & (~req + N'(1));
`endif
endmodule

// File: rtl/ahbl_arbiter.sv
// ahbl_arbiter: AHB-lite N:1 arbiter with per-port address-phase buffers; round-robin when AHBL_ARBITER_ROUND_ROBIN_EN is defined
module ahbl_arbiter
    import ahbl_arbiter_pkg::*;
#(
    parameter int N_PORTS = 2,
    parameter int W_ADDR  = 32,
    parameter int W_DATA  = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_PORTS-1:0]          src_hready,
    output logic [N_PORTS-1:0]          src_hready_resp,
    output logic [N_PORTS-1:0]          src_hresp,
    input  logic [N_PORTS*W_ADDR-1:0]   src_haddr,
    input  logic [N_PORTS*W_DATA-1:0]   src_hwdata,
    input  logic [N_PORTS-1:0]          src_hwrite,
    input  logic [N_PORTS*W_TRANS-1:0]  src_htrans,
    input  logic [N_PORTS*W_SIZE-1:0]   src_hsize,
    input  logic [N_PORTS*W_BURST-1:0]  src_hburst,
    input  logic [N_PORTS*W_PROT-1:0]   src_hprot,
    input  logic [N_PORTS-1:0]          src_hmastlock,
    output logic [N_PORTS*W_DATA-1:0]   src_hrdata,
    output logic                        dst_hready,
    input  logic                        dst_hready_resp,
    input  logic                        dst_hresp,
    output logic [W_ADDR-1:0]           dst_haddr,
    output logic                        dst_hwrite,
    output logic [W_TRANS-1:0]          dst_htrans,
    output logic [W_SIZE-1:0]           dst_hsize,
    output logic [W_BURST-1:0]          dst_hburst,
    output logic [W_PROT-1:0]           dst_hprot,
    output logic                        dst_hmastlock,
    output logic [W_DATA-1:0]           dst_hwdata,
    input  logic [W_DATA-1:0]           dst_hrdata
);
    localparam int W_AP = W_ADDR + 1 + W_TRANS + W_SIZE + W_BURST + W_PROT + 1;
    logic [W_AP-1:0]    live_ap [N_PORTS];
    logic [W_AP-1:0]    buf_ap  [N_PORTS];
    logic [W_AP-1:0]    sel_ap  [N_PORTS];
    logic [W_AP-1:0]    win_ap;
    logic [W_AP-1:0]    ap_q;
    logic [W_AP-1:0]    out_ap;
    logic [N_PORTS-1:0] live_req;
    logic [N_PORTS-1:0] req;
    logic [N_PORTS-1:0] elig;
    logic [N_PORTS-1:0] grant;
    logic [N_PORTS-1:0] buf_valid;
    logic [N_PORTS-1:0] grant_d;
    for (genvar i = 0; i < N_PORTS; i++) begin : g_port
        assign live_ap[i] = {src_haddr[i*W_ADDR +: W_ADDR], src_hwrite[i],
                             src_htrans[i*W_TRANS +: W_TRANS], src_hsize[i*W_SIZE +: W_SIZE],
                             src_hburst[i*W_BURST +: W_BURST], src_hprot[i*W_PROT +: W_PROT],
                             src_hmastlock[i]};
        assign live_req[i] = src_hready[i] && src_htrans[i*W_TRANS +: W_TRANS] != HTRANS_IDLE;
        assign sel_ap[i] = buf_valid[i] ? buf_ap[i] : live_ap[i];
        assign src_hready_resp[i] = grant_d[i] ? dst_hready_resp : !buf_valid[i];
        assign src_hrdata[i*W_DATA +: W_DATA] = dst_hrdata;
    end
    assign req = live_req | buf_valid;
    assign elig = ap_q[0] ? req & grant_d : req;
    assign src_hresp = grant_d & {N_PORTS{dst_hresp}};
    assign dst_hready = dst_hready_resp;
    assign out_ap = dst_hready_resp ? win_ap : ap_q;
    assign {dst_haddr, dst_hwrite, dst_htrans, dst_hsize, dst_hburst, dst_hprot, dst_hmastlock} = out_ap;
    ahbl_arb_pick #(.N(N_PORTS)) u_pick (
`ifdef AHBL_ARBITER_ROUND_ROBIN_EN
        .clk   (clk),
        .rst_n (rst_n),
        .adv   (dst_hready_resp && grant != '0),
`endif
        .req   (elig),
        .grant (grant)
    );
    // one-hot selects: winning address phase by current grant, write data by data-phase owner
    always_comb begin
        win_ap = '0;
        dst_hwdata = '0;
        for (int k = 0; k < N_PORTS; k++) begin
            win_ap = win_ap | (grant[k] ? sel_ap[k] : '0);
            dst_hwdata = dst_hwdata | (grant_d[k] ? src_hwdata[k*W_DATA +: W_DATA] : '0);
        end
    end
    // capture losing or stalled live requests, track data-phase owner and the issued address phase
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            buf_valid <= '0;
            grant_d <= '0;
            ap_q <= '0;
        end else begin
            for (int k = 0; k < N_PORTS; k++) begin
                if (live_req[k] && !(dst_hready_resp && grant[k])) begin
                    buf_valid[k] <= 1'b1;
                    buf_ap[k] <= live_ap[k];
                end else if (dst_hready_resp && grant[k]) begin
                    buf_valid[k] <= 1'b0;
                end
            end
            if (dst_hready_resp) begin
                grant_d <= grant;
                ap_q <= win_ap;
            end
        end
    end
endmodule

// File: tb/tb_ahbl_arbiter.sv
// tb_ahbl_arbiter: directed scoreboard bench for ahbl_arbiter (expectations follow AHBL_ARBITER_ROUND_ROBIN_EN)
module tb_ahbl_arbiter;
    import ahbl_arbiter_pkg::*;
    localparam int N = 2;
    localparam int WA = 32;
    localparam int WD = 32;
    localparam int K_ADDR = 0, K_TRANS = 1, K_RDY = 2, K_RESP = 3, K_RDATA = 4;
    localparam int K_WDATA = 5, K_WRITE = 6, K_BUF = 7, K_DRDY = 8;
    typedef struct {
        string       tag;
        int          kind;
        logic [31:0] val;
    } exp_t;
    exp_t sb[$];
    int n_cmp = 0;
    int n_err = 0;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    logic [N-1:0]    src_hready, src_hready_resp, src_hresp, src_hwrite, src_hmastlock;
    logic [N*WA-1:0] src_haddr;
    logic [N*WD-1:0] src_hwdata, src_hrdata;
    logic [N*2-1:0]  src_htrans;
    logic [N*3-1:0]  src_hsize, src_hburst;
    logic [N*4-1:0]  src_hprot;
    logic            dst_hready, dst_hready_resp, dst_hresp, dst_hwrite, dst_hmastlock;
    logic [WA-1:0]   dst_haddr;
    logic [1:0]      dst_htrans;
    logic [2:0]      dst_hsize, dst_hburst;
    logic [3:0]      dst_hprot;
    logic [WD-1:0]   dst_hwdata, dst_hrdata;
    logic [WA-1:0]   addr  [N];
    logic [1:0]      trans [N];
    logic            wr    [N];
    logic            lk    [N];
    logic [WD-1:0]   wdata [N];
    assign src_hready = src_hready_resp;
    for (genvar i = 0; i < N; i++) begin : g_src
        assign src_haddr[i*WA +: WA]  = addr[i];
        assign src_hwdata[i*WD +: WD] = wdata[i];
        assign src_htrans[i*2 +: 2]   = trans[i];
        assign src_hwrite[i]          = wr[i];
        assign src_hmastlock[i]       = lk[i];
        assign src_hsize[i*3 +: 3]    = 3'b010;
        assign src_hburst[i*3 +: 3]   = 3'b000;
        assign src_hprot[i*4 +: 4]    = 4'b0011;
    end
    ahbl_arbiter #(.N_PORTS(N), .W_ADDR(WA), .W_DATA(WD)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .src_hready      (src_hready),
        .src_hready_resp (src_hready_resp),
        .src_hresp       (src_hresp),
        .src_haddr       (src_haddr),
        .src_hwdata      (src_hwdata),
        .src_hwrite      (src_hwrite),
        .src_htrans      (src_htrans),
        .src_hsize       (src_hsize),
        .src_hburst      (src_hburst),
        .src_hprot       (src_hprot),
        .src_hmastlock   (src_hmastlock),
        .src_hrdata      (src_hrdata),
        .dst_hready      (dst_hready),
        .dst_hready_resp (dst_hready_resp),
        .dst_hresp       (dst_hresp),
        .dst_haddr       (dst_haddr),
        .dst_hwrite      (dst_hwrite),
        .dst_htrans      (dst_htrans),
        .dst_hsize       (dst_hsize),
        .dst_hburst      (dst_hburst),
        .dst_hprot       (dst_hprot),
        .dst_hmastlock   (dst_hmastlock),
        .dst_hwdata      (dst_hwdata),
        .dst_hrdata      (dst_hrdata)
    );
    function automatic logic [31:0] obs(input int k);
        case (k)
            K_ADDR:  return dst_haddr;
            K_TRANS: return 32'(dst_htrans);
            K_RDY:   return 32'(src_hready_resp);
            K_RESP:  return 32'(src_hresp);
            K_RDATA: return src_hrdata[31:0];
            K_WDATA: return dst_hwdata;
            K_WRITE: return 32'(dst_hwrite);
            K_BUF:   return 32'(dut.buf_valid);
            K_DRDY:  return 32'(dst_hready);
            default: return 'x;
        endcase
    endfunction
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    task automatic want(input string tag, input int kind, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.kind = kind;
        e.val = val;
        sb.push_back(e);
    endtask
    task automatic tick();
        @(negedge clk);
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check(e.tag, obs(e.kind), e.val);
        end
        @(posedge clk);
        #1;
    endtask
    task automatic master(input int p, input logic [1:0] t, input logic [31:0] a, input logic w, input logic l);
        trans[p] = t;
        addr[p] = a;
        wr[p] = w;
        lk[p] = l;
    endtask
    task automatic idle_all();
        for (int p = 0; p < N; p++) master(p, HTRANS_IDLE, '0, 1'b0, 1'b0);
    endtask
    task automatic slave(input logic r, input logic e, input logic [31:0] d);
        dst_hready_resp = r;
        dst_hresp = e;
        dst_hrdata = d;
    endtask
    initial begin
        idle_all();
        wdata[0] = '0;
        wdata[1] = '0;
        slave(1'b1, 1'b0, '0);
        tick();
        tick();
        rst_n = 1'b1;
        want("rst_rdy", K_RDY, 32'h3);
        want("rst_resp", K_RESP, 32'h0);
        want("rst_trans", K_TRANS, 32'(HTRANS_IDLE));
        want("rst_buf", K_BUF, 32'h0);
        want("rst_dhready", K_DRDY, 32'h1);
        tick();
        // single master read, zero wait
        master(0, HTRANS_NONSEQ, 32'h2000_0000, 1'b0, 1'b0);
        want("single_addr", K_ADDR, 32'h2000_0000);
        want("single_trans", K_TRANS, 32'(HTRANS_NONSEQ));
        want("single_rdy_a", K_RDY, 32'h3);
        tick();
        idle_all();
        slave(1'b1, 1'b0, 32'hDEAD_BEEF);
        want("single_rdy_d", K_RDY, 32'h3);
        want("single_rdata", K_RDATA, 32'hDEAD_BEEF);
        want("single_idle", K_TRANS, 32'(HTRANS_IDLE));
        tick();
        // two-cycle error to port 1
        master(1, HTRANS_NONSEQ, 32'h500, 1'b0, 1'b0);
        slave(1'b1, 1'b0, '0);
        want("err_addr", K_ADDR, 32'h500);
        tick();
        idle_all();
        slave(1'b0, 1'b1, '0);
        want("err_resp1", K_RESP, 32'h2);
        want("err_rdy1", K_RDY, 32'h1);
        tick();
        slave(1'b1, 1'b1, '0);
        want("err_resp2", K_RESP, 32'h2);
        want("err_rdy2", K_RDY, 32'h3);
        tick();
        slave(1'b1, 1'b0, '0);
        want("err_after", K_RESP, 32'h0);
        tick();
        // collision: port 0 passes through, port 1 buffered
        master(0, HTRANS_NONSEQ, 32'h100, 1'b1, 1'b0);
        master(1, HTRANS_NONSEQ, 32'h200, 1'b0, 1'b0);
        want("col_addr0", K_ADDR, 32'h100);
        want("col_write0", K_WRITE, 32'h1);
        want("col_rdy0", K_RDY, 32'h3);
        tick();
        idle_all();
        wdata[0] = 32'hAAAA_0001;
        want("col_addr1", K_ADDR, 32'h200);
        want("col_trans1", K_TRANS, 32'(HTRANS_NONSEQ));
        want("col_write1", K_WRITE, 32'h0);
        want("col_wdata0", K_WDATA, 32'hAAAA_0001);
        want("col_rdy1", K_RDY, 32'h1);
        tick();
        slave(1'b1, 1'b0, 32'h1234_5678);
        want("col_rdy2", K_RDY, 32'h3);
        want("col_rdata", K_RDATA, 32'h1234_5678);
        tick();
        // wait states during port 0 data phase while port 1 requests
        master(0, HTRANS_NONSEQ, 32'h300, 1'b1, 1'b0);
        slave(1'b1, 1'b0, '0);
        want("ws_addr0", K_ADDR, 32'h300);
        tick();
        master(0, HTRANS_IDLE, '0, 1'b0, 1'b0);
        wdata[0] = 32'hBBBB_0000;
        master(1, HTRANS_NONSEQ, 32'h400, 1'b0, 1'b0);
        slave(1'b0, 1'b0, '0);
        want("ws_hold", K_ADDR, 32'h300);
        want("ws_wdata0", K_WDATA, 32'hBBBB_0000);
        want("ws_rdy_w1", K_RDY, 32'h2);
        tick();
        idle_all();
        want("ws_rdy_w2", K_RDY, 32'h0);
        want("ws_buf", K_BUF, 32'h2);
        tick();
        want("ws_rdy_w3", K_RDY, 32'h0);
        tick();
        slave(1'b1, 1'b0, '0);
        want("ws_rel_addr", K_ADDR, 32'h400);
        want("ws_rel_trans", K_TRANS, 32'(HTRANS_NONSEQ));
        want("ws_rel_wdata", K_WDATA, 32'hBBBB_0000);
        want("ws_rel_rdy", K_RDY, 32'h1);
        tick();
        wdata[0] = '0;
        wdata[1] = 32'hCCCC_0001;
        want("ws_wdata1", K_WDATA, 32'hCCCC_0001);
        want("ws_rdy_end", K_RDY, 32'h3);
        tick();
        // locked three-transfer sequence from port 0 while port 1 waits
        master(0, HTRANS_NONSEQ, 32'h600, 1'b0, 1'b1);
        master(1, HTRANS_NONSEQ, 32'h700, 1'b0, 1'b0);
        want("lk_addr0", K_ADDR, 32'h600);
        tick();
        master(0, HTRANS_NONSEQ, 32'h604, 1'b0, 1'b1);
        master(1, HTRANS_IDLE, '0, 1'b0, 1'b0);
        want("lk_addr1", K_ADDR, 32'h604);
        want("lk_rdy1", K_RDY, 32'h1);
        tick();
        master(0, HTRANS_NONSEQ, 32'h608, 1'b0, 1'b1);
        want("lk_addr2", K_ADDR, 32'h608);
        tick();
        idle_all();
        want("lk_gap", K_TRANS, 32'(HTRANS_IDLE));
        want("lk_rdy_gap", K_RDY, 32'h1);
        tick();
        want("lk_p1_addr", K_ADDR, 32'h700);
        want("lk_p1_trans", K_TRANS, 32'(HTRANS_NONSEQ));
        tick();
        want("lk_rdy_end", K_RDY, 32'h3);
        tick();
        // continuous requests from both ports
        master(0, HTRANS_NONSEQ, 32'h800, 1'b0, 1'b0);
        master(1, HTRANS_NONSEQ, 32'h900, 1'b0, 1'b0);
        for (int c = 0; c < 4; c++) begin
`ifdef AHBL_ARBITER_ROUND_ROBIN_EN
            want($sformatf("cont_%0d", c), K_ADDR, (c % 2 == 0) ? 32'h800 : 32'h900);
`else
            want($sformatf("cont_%0d", c), K_ADDR, 32'h800);
`endif
            tick();
        end
        idle_all();
        for (int c = 0; c < 3; c++) tick();
        // reset while a port is buffered
        master(0, HTRANS_NONSEQ, 32'hA00, 1'b0, 1'b0);
        master(1, HTRANS_NONSEQ, 32'hB00, 1'b0, 1'b0);
        tick();
        idle_all();
        rst_n = 1'b0;
`ifdef AHBL_ARBITER_ROUND_ROBIN_EN
        want("rr_buf_pre", K_BUF, 32'h1);
`else
        want("rr_buf_pre", K_BUF, 32'h2);
`endif
        tick();
        rst_n = 1'b1;
        want("rr_buf_post", K_BUF, 32'h0);
        want("rr_rdy_post", K_RDY, 32'h3);
        want("rr_trans_post", K_TRANS, 32'(HTRANS_IDLE));
        want("rr_resp_post", K_RESP, 32'h0);
        tick();
        want("rr_trans_idle", K_TRANS, 32'(HTRANS_IDLE));
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
